// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI responder: register select codes and STATUS bit positions.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    localparam int STS_D2H_FULL  = 0;
    localparam int STS_H2D_VALID = 1;
    localparam int STS_OVF       = 2;

endpackage

// File: rtl/hpi_mailbox.sv
// One-entry 16-bit mailbox: load overwrites, consume empties, sticky overflow when a full
// entry is overwritten without being consumed in the same cycle.
module hpi_mailbox (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] load_data_i,
    input  logic        consume_i,
    input  logic        ovf_clr_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        ovf_o
);

    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        data_d  = load_i ? load_data_i : data_q;
        // A load in the consume cycle keeps the entry full and is not an overflow.
        valid_d = load_i | (valid_q & ~consume_i);
        ovf_d   = (load_i & valid_q & ~consume_i) | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/hpi_device_port.sv
// Device (responder) side of the 16-bit HPI bus: DATA/MAILBOX/ADDRESS/STATUS registers,
// word memory behind an auto-incrementing byte pointer, and two mailboxes to a local agent.
module hpi_device_port
    import hpi_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        Clk,
    input  logic        Reset_N,
    inout  wire  [15:0] OTG_DATA,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_CS_N,
    output logic        OTG_INT,
    output logic [15:0] h2d_data,
    output logic        h2d_valid,
    input  logic        h2d_ready,
    input  logic [15:0] d2h_data,
    input  logic        d2h_valid,
    output logic        d2h_ready
);

    localparam int AW = $clog2(MEM_WORDS) + 1;

    logic [15:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          drive_q, drive_d;
    logic          rd_hist_q, wr_hist_q;

    hpi_reg_e      reg_sel;
    logic          rd_acc, wr_acc, data_acc;
    logic [15:0]   sts;
    logic [15:0]   d2h_word;
    logic          d2h_full, h2d_ovf, d2h_ovf_unused;

    // History resets to "asserted" so a strobe already low at reset release is not an access.
    assign rd_acc   = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N & rd_hist_q;
    assign wr_acc   = ~OTG_CS_N & ~OTG_WR_N & OTG_RD_N & wr_hist_q;
    assign reg_sel  = hpi_reg_e'(OTG_ADDR);
    assign data_acc = (rd_acc | wr_acc) & (reg_sel == HPI_DATA);

    hpi_mailbox u_h2d (
        .clk_i       (Clk),
        .rst_ni      (Reset_N),
        .load_i      (wr_acc & (reg_sel == HPI_MAILBOX)),
        .load_data_i (OTG_DATA),
        .consume_i   (h2d_valid & h2d_ready),
        .ovf_clr_i   (rd_acc & (reg_sel == HPI_STATUS)),
        .data_o      (h2d_data),
        .valid_o     (h2d_valid),
        .ovf_o       (h2d_ovf)
    );

    // Pushes are gated by ready, so this side never overflows.
    hpi_mailbox u_d2h (
        .clk_i       (Clk),
        .rst_ni      (Reset_N),
        .load_i      (d2h_valid & ~d2h_full),
        .load_data_i (d2h_data),
        .consume_i   (rd_acc & (reg_sel == HPI_MAILBOX)),
        .ovf_clr_i   (1'b0),
        .data_o      (d2h_word),
        .valid_o     (d2h_full),
        .ovf_o       (d2h_ovf_unused)
    );

    always_comb begin
        sts                = '0;
        sts[STS_D2H_FULL]  = d2h_full;
        sts[STS_H2D_VALID] = h2d_valid;
        sts[STS_OVF]       = h2d_ovf;
    end

    always_comb begin
        addr_d = addr_q;
        if (wr_acc && reg_sel == HPI_ADDRESS)
            addr_d = {OTG_DATA[AW-1:1], 1'b0};
        else if (data_acc)
            addr_d = addr_q + AW'(2);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) begin
            case (reg_sel)
                HPI_DATA:    rdata_d = mem_q[addr_q[AW-1:1]];
                HPI_MAILBOX: rdata_d = d2h_word;
                HPI_ADDRESS: rdata_d = 16'(addr_q);
                default:     rdata_d = sts;
            endcase
        end
    end

    // Drive holds through the strobe and drops at the edge ending the first idle cycle.
    always_comb begin
        drive_d = drive_q;
        if (rd_acc)
            drive_d = 1'b1;
        else if (OTG_RD_N || OTG_CS_N)
            drive_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            addr_q    <= '0;
            rdata_q   <= '0;
            drive_q   <= 1'b0;
            rd_hist_q <= 1'b0;
            wr_hist_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            drive_q   <= drive_d;
            rd_hist_q <= OTG_RD_N;
            wr_hist_q <= OTG_WR_N;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_acc && reg_sel == HPI_DATA)
            mem_q[addr_q[AW-1:1]] <= OTG_DATA;
    end

    assign OTG_DATA  = drive_q ? rdata_q : 16'bz;
    assign OTG_INT   = d2h_full;
    assign d2h_ready = ~d2h_full;

endmodule

// File: tb/tb_hpi_device_port.sv
// Self-checking bench for hpi_device_port: directed scenarios plus a randomized op mix
// compared against a register-level model of the host-visible behaviour.
module tb_hpi_device_port;

    localparam int MW = 256;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    tri1  [15:0] OTG_DATA;
    logic [1:0]  addr = 2'd0;
    logic        rd_n = 1'b1, wr_n = 1'b1, cs_n = 1'b1;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_wdata = 16'h0;
    logic        OTG_INT;
    logic [15:0] h2d_data;
    logic        h2d_valid;
    logic        h2d_ready = 1'b0;
    logic [15:0] d2h_data = 16'h0;
    logic        d2h_valid = 1'b0;
    logic        d2h_ready;

    int checks = 0;
    int errors = 0;

    assign OTG_DATA = tb_drv ? tb_wdata : 16'bz;

    always #5 Clk = ~Clk;

    hpi_device_port #(.MEM_WORDS(MW)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .OTG_DATA(OTG_DATA), .OTG_ADDR(addr),
        .OTG_RD_N(rd_n), .OTG_WR_N(wr_n), .OTG_CS_N(cs_n), .OTG_INT(OTG_INT),
        .h2d_data(h2d_data), .h2d_valid(h2d_valid), .h2d_ready(h2d_ready),
        .d2h_data(d2h_data), .d2h_valid(d2h_valid), .d2h_ready(d2h_ready)
    );

    // Reference model: host-visible state as plain variables
    logic [15:0] m_mem [MW];
    int          m_addr;
    logic        m_h2d_v, m_d2h_full, m_ovf;
    logic [15:0] m_h2d_d, m_d2h_d;

    function automatic void m_reset();
        m_addr = 0; m_h2d_v = 0; m_d2h_full = 0; m_ovf = 0; m_h2d_d = 0; m_d2h_d = 0;
    endfunction

    function automatic void m_write(input logic [1:0] a, input logic [15:0] d);
        case (a)
            2'd0: begin m_mem[m_addr / 2] = d; m_addr = (m_addr + 2) % (2 * MW); end
            2'd1: begin if (m_h2d_v) m_ovf = 1; m_h2d_d = d; m_h2d_v = 1; end
            2'd2: m_addr = int'(d) % (2 * MW) / 2 * 2;
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] a);
        logic [15:0] r;
        case (a)
            2'd0: begin r = m_mem[m_addr / 2]; m_addr = (m_addr + 2) % (2 * MW); end
            2'd1: begin r = m_d2h_d; m_d2h_full = 0; end
            2'd2: r = 16'(m_addr);
            default: begin r = {13'd0, m_ovf, m_h2d_v, m_d2h_full}; m_ovf = 0; end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        cs_n = 0; addr = a; wr_n = 0; tb_drv = 1; tb_wdata = d;
        tick();
        wr_n = 1; cs_n = 1; tb_drv = 0;
        tick();
        m_write(a, d);
    endtask

    task automatic host_read(input logic [1:0] a, output logic [15:0] d);
        cs_n = 0; addr = a; rd_n = 0;
        tick();
        d = OTG_DATA;
        rd_n = 1; cs_n = 1;
        tick();
    endtask

    task automatic push_d2h(input logic [15:0] v);
        d2h_data = v; d2h_valid = 1;
        tick();
        d2h_valid = 0;
        if (!m_d2h_full) begin m_d2h_full = 1; m_d2h_d = v; end
    endtask

    task automatic test_reset();
        logic [15:0] got, exp;
        Reset_N = 0; m_reset();
        repeat (2) tick();
        checks++; if (OTG_DATA !== 16'hFFFF) begin errors++; $display("FAIL reset_bus got=%h exp=released", OTG_DATA); end
        checks++; if ({OTG_INT, h2d_valid, d2h_ready} !== 3'b001) begin errors++; $display("FAIL reset_flags got=%b exp=001", {OTG_INT, h2d_valid, d2h_ready}); end
        checks++; if (h2d_data !== 16'h0) begin errors++; $display("FAIL reset_h2d_data got=%h exp=0000", h2d_data); end
        Reset_N = 1;
        repeat (2) tick();
        host_read(2'd2, got); exp = m_read(2'd2);
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_address got=%h exp=%h", got, exp); end
        host_read(2'd3, got); exp = m_read(2'd3);
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_status got=%h exp=%h", got, exp); end
    endtask

    task automatic test_data_seq();
        logic [15:0] got, exp;
        host_write(2'd2, 16'h0010);
        host_write(2'd0, 16'hAAAA);
        host_write(2'd0, 16'h5555);
        host_write(2'd2, 16'h0010);
        for (int i = 0; i < 2; i++) begin
            host_read(2'd0, got); exp = m_read(2'd0);
            checks++; if (got !== exp) begin errors++; $display("FAIL seq_data%0d got=%h exp=%h", i, got, exp); end
        end
        host_read(2'd2, got); exp = m_read(2'd2);
        checks++; if (got !== exp) begin errors++; $display("FAIL seq_address got=%h exp=%h", got, exp); end
    endtask

    task automatic test_wrap();
        logic [15:0] got, exp;
        host_write(2'd2, 16'h01FE);
        host_write(2'd0, 16'h1234);
        host_read(2'd2, got); exp = m_read(2'd2);
        checks++; if (got !== exp) begin errors++; $display("FAIL wrap_address got=%h exp=%h", got, exp); end
        host_write(2'd2, 16'h01FE);
        host_read(2'd0, got); exp = m_read(2'd0);
        checks++; if (got !== exp) begin errors++; $display("FAIL wrap_data got=%h exp=%h", got, exp); end
    endtask

    task automatic test_d2h();
        logic [15:0] got, exp;
        push_d2h(16'hBEEF);
        checks++; if ({OTG_INT, d2h_ready} !== 2'b10) begin errors++; $display("FAIL d2h_full got=%b exp=10", {OTG_INT, d2h_ready}); end
        push_d2h(16'h4444);
        cs_n = 0; addr = 2'd1; rd_n = 0;
        #1;
        checks++; if (OTG_INT !== 1'b1) begin errors++; $display("FAIL d2h_int_before got=%b exp=1", OTG_INT); end
        tick();
        got = OTG_DATA; exp = m_read(2'd1);
        checks++; if (got !== exp) begin errors++; $display("FAIL d2h_read got=%h exp=%h", got, exp); end
        checks++; if (OTG_INT !== 1'b0) begin errors++; $display("FAIL d2h_int_after got=%b exp=0", OTG_INT); end
        rd_n = 1; cs_n = 1;
        tick();
        host_read(2'd1, got); exp = m_read(2'd1);
        checks++; if (got !== exp || OTG_INT !== 1'b0) begin errors++; $display("FAIL d2h_empty_read got=%h/%b exp=%h/0", got, OTG_INT, exp); end
    endtask

    task automatic test_h2d();
        logic [15:0] got, exp;
        h2d_ready = 0;
        host_write(2'd1, 16'h0001);
        host_write(2'd1, 16'h0002);
        checks++; if (h2d_data !== m_h2d_d || h2d_valid !== 1'b1) begin errors++; $display("FAIL h2d_overwrite got=%h/%b exp=%h/1", h2d_data, h2d_valid, m_h2d_d); end
        for (int i = 0; i < 2; i++) begin
            host_read(2'd3, got); exp = m_read(2'd3);
            checks++; if (got !== exp) begin errors++; $display("FAIL h2d_status%0d got=%h exp=%h", i, got, exp); end
        end
        h2d_ready = 1; tick(); h2d_ready = 0; m_h2d_v = 0;
        checks++; if (h2d_valid !== 1'b0) begin errors++; $display("FAIL h2d_consume got=%b exp=0", h2d_valid); end
        host_write(2'd1, 16'h0033);
        // write lands in the same cycle the agent consumes the previous word
        cs_n = 0; addr = 2'd1; wr_n = 0; tb_drv = 1; tb_wdata = 16'h0044; h2d_ready = 1;
        tick();
        wr_n = 1; cs_n = 1; tb_drv = 0; h2d_ready = 0;
        m_h2d_d = 16'h0044;
        tick();
        checks++; if (h2d_data !== m_h2d_d || h2d_valid !== 1'b1) begin errors++; $display("FAIL h2d_same_cycle got=%h/%b exp=%h/1", h2d_data, h2d_valid, m_h2d_d); end
        host_read(2'd3, got); exp = m_read(2'd3);
        checks++; if (got !== exp) begin errors++; $display("FAIL h2d_no_ovf got=%h exp=%h", got, exp); end
        h2d_ready = 1; tick(); h2d_ready = 0; m_h2d_v = 0;
    endtask

    task automatic test_hold_rd();
        logic [15:0] got, exp;
        host_write(2'd2, 16'h0010);
        cs_n = 0; addr = 2'd0; rd_n = 0;
        exp = m_read(2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (OTG_DATA !== exp) begin errors++; $display("FAIL hold_driven%0d got=%h exp=%h", i, OTG_DATA, exp); end
        end
        rd_n = 1; cs_n = 1;
        #1;
        checks++; if (OTG_DATA !== exp) begin errors++; $display("FAIL hold_release_cycle got=%h exp=%h", OTG_DATA, exp); end
        tick();
        checks++; if (OTG_DATA !== 16'hFFFF) begin errors++; $display("FAIL hold_released got=%h exp=released", OTG_DATA); end
        host_read(2'd2, got); exp = m_read(2'd2);
        checks++; if (got !== exp) begin errors++; $display("FAIL hold_single_inc got=%h exp=%h", got, exp); end
        cs_n = 0; addr = 2'd0; rd_n = 0; wr_n = 0;
        repeat (2) begin
            tick();
            checks++; if (OTG_DATA !== 16'hFFFF) begin errors++; $display("FAIL both_low_bus got=%h exp=released", OTG_DATA); end
        end
        rd_n = 1; wr_n = 1; cs_n = 1;
        tick();
        host_read(2'd2, got); exp = m_read(2'd2);
        checks++; if (got !== exp) begin errors++; $display("FAIL both_low_address got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, exp;
        push_d2h(16'h1357);
        host_write(2'd2, 16'h0010);
        cs_n = 0; addr = 2'd0; rd_n = 0;
        tick();
        exp = m_read(2'd0);
        checks++; if (OTG_DATA !== exp) begin errors++; $display("FAIL rstmid_driven got=%h exp=%h", OTG_DATA, exp); end
        #1 Reset_N = 0;
        #1;
        checks++; if (OTG_DATA !== 16'hFFFF || OTG_INT !== 1'b0) begin errors++; $display("FAIL rstmid_async got=%h/%b exp=released/0", OTG_DATA, OTG_INT); end
        m_reset();
        repeat (2) tick();
        Reset_N = 1;
        repeat (3) begin
            tick();
            checks++; if (OTG_DATA !== 16'hFFFF) begin errors++; $display("FAIL rstmid_held_strobe got=%h exp=released", OTG_DATA); end
        end
        rd_n = 1; cs_n = 1;
        tick();
        host_read(2'd2, got); exp = m_read(2'd2);
        checks++; if (got !== exp) begin errors++; $display("FAIL rstmid_address got=%h exp=%h", got, exp); end
        host_write(2'd2, 16'h0010);
        host_read(2'd0, got); exp = m_read(2'd0);
        checks++; if (got !== exp) begin errors++; $display("FAIL rstmid_mem_kept got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        logic [15:0] got, exp, v;
        int op;
        host_write(2'd2, 16'h0000);
        for (int i = 0; i < MW; i++) host_write(2'd0, 16'($urandom) & 16'h7FFF);
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 8));
            v  = 16'($urandom);
            case (op)
                0: host_write(2'd0, v & 16'h7FFF);
                1: host_write(2'd1, v);
                2: host_write(2'd2, v);
                3: host_write(2'd3, v);
                4: push_d2h(v & 16'h7FFF);
                5: begin h2d_ready = 1; tick(); h2d_ready = 0; m_h2d_v = 0; end
                default: begin
                    host_read(2'(op - 5), got); exp = m_read(2'(op - 5));
                    checks++; if (got !== exp) begin errors++; $display("FAIL rand_read%0d reg=%0d got=%h exp=%h", i, op - 5, got, exp); end
                end
            endcase
            checks++;
            if ({OTG_INT, d2h_ready, h2d_valid} !== {m_d2h_full, ~m_d2h_full, m_h2d_v} || h2d_data !== m_h2d_d) begin
                errors++;
                $display("FAIL rand_flags%0d got=%b/%h exp=%b/%h", i, {OTG_INT, d2h_ready, h2d_valid}, h2d_data,
                         {m_d2h_full, ~m_d2h_full, m_h2d_v}, m_h2d_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_seq();
        test_wrap();
        test_d2h();
        test_h2d();
        test_hold_rd();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
